// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler that shares one UART byte transmitter between
// N_REQ byte producers. One byte is taken at a time over valid/ready.
// The byte is launched with a start strobe. The next grant waits until the
// transmitter's active-low done has asserted and then released.
//
// Ports:
//   i_clk        system clock, rising edge
//   i_rst        synchronous active-low reset
//   i_req_valid  per-requester byte pending
//   i_req_data   requester k byte in [k*NB_DATA +: NB_DATA]
//   o_req_ready  one-hot one-cycle pulse: requester's byte taken
//   i_tx_done_n  transmitter done, active-low, asserted at end of stop bit
//   o_tx_start   one-cycle start strobe to the transmitter
//   o_tx_data    byte to the transmitter, stable from START until IDLE
//   o_grant_id   index of the requester currently or last served
//   o_busy       high whenever not IDLE
module uart_tx_arbiter #(
  parameter int unsigned NB_DATA = 8,
  parameter int unsigned N_REQ   = 2,
  parameter int unsigned NB_ID   = 1
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [N_REQ-1:0]         i_req_valid,
  input  logic [N_REQ*NB_DATA-1:0] i_req_data,
  output logic [N_REQ-1:0]         o_req_ready,
  input  logic                     i_tx_done_n,
  output logic                     o_tx_start,
  output logic [NB_DATA-1:0]       o_tx_data,
  output logic [NB_ID-1:0]         o_grant_id,
  output logic                     o_busy
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_START   = 2'd1,
    S_BUSY    = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [NB_ID-1:0]     r_last;
  logic [NB_ID-1:0]     w_last_nxt;
  logic [NB_ID-1:0]     r_grant;
  logic [NB_ID-1:0]     w_grant_nxt;
  logic [NB_DATA-1:0]   r_data;
  logic [NB_DATA-1:0]   w_data_nxt;
  logic [N_REQ-1:0]     r_ready;
  logic [N_REQ-1:0]     w_ready_nxt;
  logic                 r_start;
  logic                 w_start_nxt;
  logic                 r_busy;
  logic                 w_busy_nxt;

  // Round-robin candidates: lowest valid index above the last grant,
  // otherwise the lowest valid index at or below it (wrap-around).
  logic                 w_hi_vld;
  logic [NB_ID-1:0]     w_hi_id;
  logic [NB_DATA-1:0]   w_hi_data;
  logic [NB_ID-1:0]     w_lo_id;
  logic [NB_DATA-1:0]   w_lo_data;
  logic [NB_ID-1:0]     w_pick_id;
  logic [NB_DATA-1:0]   w_pick_data;

  // Descending scan so the lowest qualifying index is the one that sticks.
  always_comb begin
    w_hi_vld  = 1'b0;
    w_hi_id   = '0;
    w_hi_data = '0;
    w_lo_id   = '0;
    w_lo_data = '0;
    for (int k = int'(N_REQ) - 1; k >= 0; k--) begin
      if (i_req_valid[k]) begin
        if (k > int'(r_last)) begin
          w_hi_vld  = 1'b1;
          w_hi_id   = NB_ID'(k);
          w_hi_data = i_req_data[k*NB_DATA +: NB_DATA];
        end else begin
          w_lo_id   = NB_ID'(k);
          w_lo_data = i_req_data[k*NB_DATA +: NB_DATA];
        end
      end
    end
    w_pick_id   = w_hi_vld ? w_hi_id   : w_lo_id;
    w_pick_data = w_hi_vld ? w_hi_data : w_lo_data;
  end

  // Next state and next register values.
  always_comb begin
    w_state_nxt = r_state;
    w_last_nxt  = r_last;
    w_grant_nxt = r_grant;
    w_data_nxt  = r_data;
    w_ready_nxt = '0;
    w_start_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (|i_req_valid) begin
          w_state_nxt = S_START;
          w_grant_nxt = w_pick_id;
          w_data_nxt  = w_pick_data;
          w_start_nxt = 1'b1;
          w_ready_nxt = N_REQ'(1) << w_pick_id;
        end
      end
      S_START: begin
        w_state_nxt = S_BUSY;
      end
      S_BUSY: begin
        if (!i_tx_done_n) begin
          w_state_nxt = S_RELEASE;
        end
      end
      S_RELEASE: begin
        // Hold off any new start until done is released.
        if (i_tx_done_n) begin
          w_state_nxt = S_IDLE;
          w_last_nxt  = r_grant;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state <= S_IDLE;
      r_last  <= NB_ID'(N_REQ - 1);
      r_grant <= '0;
      r_data  <= '0;
      r_ready <= '0;
      r_start <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_last  <= w_last_nxt;
      r_grant <= w_grant_nxt;
      r_data  <= w_data_nxt;
      r_ready <= w_ready_nxt;
      r_start <= w_start_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  assign o_req_ready = r_ready;
  assign o_tx_start  = r_start;
  assign o_tx_data   = r_data;
  assign o_grant_id  = r_grant;
  assign o_busy      = r_busy;

endmodule
